// File: rtl/sfifo_param_if.sv
// Producer/consumer handshake bundle for sfifo_param. The "slave" side is the FIFO;
// the "master" side is the producer/consumer pair driving push/pop.
interface sfifo_param_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
);
   logic [DATA_W-1:0]        data_in;
   logic                     push;
   logic                     full;
   logic                     almost_full;
   logic [DATA_W-1:0]        data_out;
   logic                     pop;
   logic                     empty;
   logic                     almost_empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output data_in, push, pop,
      input  full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
   );
   modport slave (
      input  data_in, push, pop,
      output full, almost_full, data_out, empty, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, sticky
// overflow/underflow flags and optional first-word-fall-through read port.
module sfifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter bit FWFT      = 1'b0
) (
   input logic          clk,
   input logic          rst,
   sfifo_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CW-1:0]     wr_ptr, rd_ptr, occ;
   logic              is_full, is_empty, do_push, do_pop;
   logic              ovf, unf;
   logic [DATA_W-1:0] head;

   // Occupancy falls out of the wrap-extended pointers, so every status flag
   // is decoded from registered state only.
   assign occ      = wr_ptr - rd_ptr;
   assign is_full  = (occ == CW'(DEPTH));
   assign is_empty = (occ == '0);
   assign do_push  = bus.push && !is_full;
   assign do_pop   = bus.pop && !is_empty;
   assign head     = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + CW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
         if (bus.push && is_full)  ovf <= 1'b1;
         if (bus.pop && is_empty)  unf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= bus.data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out = is_empty ? '0 : head;
      end else begin : g_std
         logic [DATA_W-1:0] rdata;
         always_ff @(posedge clk) begin
            if (rst)         rdata <= '0;
            else if (do_pop) rdata <= head;
         end
         assign bus.data_out = rdata;
      end
   endgenerate

   assign bus.count        = occ;
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.almost_full  = (occ >= CW'(AF_THRESH));
   assign bus.almost_empty = (occ <= CW'(AE_THRESH));
   assign bus.overflow     = ovf;
   assign bus.underflow    = unf;
endmodule

// File: tb/tb_sfifo_param.sv
// Scoreboard bench: one stimulus stream drives a standard and an FWFT FIFO
// (DEPTH=4); a queue-based model predicts both, a monitor checks after each edge.
module tb_sfifo_param;
   localparam int DW = 8;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sfifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
   sfifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

   sfifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(2), .AE_THRESH(2), .FWFT(1'b0))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   sfifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(2), .AE_THRESH(2), .FWFT(1'b1))
      dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct {
      logic [2:0]    cnt;
      logic          emp, ful, af, ae, ovf, unf;
      logic [DW-1:0] d0, d1;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] mq[$];
   logic          m_ovf = 1'b0, m_unf = 1'b0;
   logic [DW-1:0] m_d0 = '0;
   int            errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Drive one cycle, advance the reference model, queue the expected outputs.
   task automatic step(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
      exp_t e;
      int   sz;
      logic acc_push, acc_pop;
      @(negedge clk);
      rst = r;
      if0.push = p; if0.pop = q; if0.data_in = d;
      if1.push = p; if1.pop = q; if1.data_in = d;
      sz = mq.size();
      if (r) begin
         mq.delete();
         m_ovf = 1'b0; m_unf = 1'b0; m_d0 = '0;
      end else begin
         acc_push = p && (sz < DP);
         acc_pop  = q && (sz > 0);
         if (p && sz == DP) m_ovf = 1'b1;
         if (q && sz == 0)  m_unf = 1'b1;
         if (acc_pop)  m_d0 = mq.pop_front();
         if (acc_push) mq.push_back(d);
      end
      sz    = mq.size();
      e.cnt = 3'(sz);
      e.emp = (sz == 0);
      e.ful = (sz == DP);
      e.af  = (sz >= 2);
      e.ae  = (sz <= 2);
      e.ovf = m_ovf;
      e.unf = m_unf;
      e.d0  = m_d0;
      e.d1  = (sz > 0) ? mq[0] : '0;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count0", 32'(if0.count), 32'(e.cnt));
            chk("empty0", 32'(if0.empty), 32'(e.emp));
            chk("full0", 32'(if0.full), 32'(e.ful));
            chk("almost_full0", 32'(if0.almost_full), 32'(e.af));
            chk("almost_empty0", 32'(if0.almost_empty), 32'(e.ae));
            chk("overflow0", 32'(if0.overflow), 32'(e.ovf));
            chk("underflow0", 32'(if0.underflow), 32'(e.unf));
            chk("data_out_std", 32'(if0.data_out), 32'(e.d0));
            chk("count1", 32'(if1.count), 32'(e.cnt));
            chk("empty1", 32'(if1.empty), 32'(e.emp));
            chk("full1", 32'(if1.full), 32'(e.ful));
            chk("overflow1", 32'(if1.overflow), 32'(e.ovf));
            chk("underflow1", 32'(if1.underflow), 32'(e.unf));
            chk("data_out_fwft", 32'(if1.data_out), 32'(e.d1));
         end
      end
   end

   initial begin : driver
      logic [DW-1:0] fill [4];
      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
      if0.push = 1'b0; if0.pop = 1'b0; if0.data_in = '0;
      if1.push = 1'b0; if1.pop = 1'b0; if1.data_in = '0;

      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      // fill, overflow, drain, underflow
      for (int i = 0; i < 4; i++) step(0, 1, 0, fill[i]);
      step(0, 1, 0, 8'h55);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      // simultaneous push/pop at count 2, when full, when empty
      step(1, 0, 0, 0);
      step(0, 1, 0, 8'h01);
      step(0, 1, 0, 8'h02);
      step(0, 1, 1, 8'h03);
      step(0, 1, 0, 8'h04);
      step(0, 1, 0, 8'h05);
      step(0, 1, 1, 8'h06);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 1, 1, 8'h07);
      step(0, 0, 1, 0);
      // FWFT single word, then wrap-around with ascending data
      step(1, 0, 0, 0);
      step(0, 1, 0, 8'hA5);
      step(0, 0, 1, 0);
      for (int i = 0; i < 3 * DP; i++) step(0, 1, (i > 0), 8'(i));
      step(0, 0, 1, 0);
      // reset mid-stream together with a push
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h60 + i));
      step(1, 1, 0, 8'h77);
      step(0, 0, 1, 0);
      // randomized traffic with alternating bias and rare resets
      for (int c = 0; c < 3000; c++) begin
         int bias;
         bias = ((c / 150) % 2 == 1) ? 75 : 25;
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < bias),
              ($urandom_range(0, 99) < (100 - bias)),
              8'($urandom_range(0, 255)));
      end
      @(negedge clk);
      if0.push = 1'b0; if0.pop = 1'b0; if1.push = 1'b0; if1.pop = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
